// File: rtl/cprv_ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
//   id_t         : requester identifier (1 bit)
//   M0, M1       : requester ID constants
//   lock_state_t : grant-lock FSM states
package cprv_ram_arb_pkg;

    typedef logic id_t;

    localparam id_t M0 = 1'b0;
    localparam id_t M1 = 1'b1;

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_HOLD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/cprv_tag_fifo.sv
// In-order FIFO of requester IDs for requests awaiting a RAM response.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : enqueue din (ignored when full)
//   pop      : dequeue head (ignored when empty)
//   dout     : head entry
//   full     : DEPTH entries held
//   empty    : no entries held
module cprv_tag_fifo
    import cprv_ram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  id_t  din,
    output id_t  dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    id_t           mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers, occupancy and storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= M0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cprv_ram_arb_2to1.sv
// Two-requester round-robin arbiter in front of a single RAM wrapper.
// Requests are forwarded combinationally from the granted requester; a tag
// FIFO remembers who was granted so in-order responses can be routed back.
//   clk, rst                 : clock, asynchronous active-high reset
//   mK_valid_i/mK_ready_o    : request handshake from requester K
//   mK_w_en/mK_addr/mK_wdata : request payload from requester K
//   mK_valid_o/mK_ready_i    : response handshake to requester K
//   mK_rdata                 : response data to requester K
//   s_valid_o/s_ready_i      : request handshake to the RAM wrapper
//   s_w_en/s_addr/s_wdata    : request payload to the RAM wrapper
//   s_valid_i/s_ready_o      : response handshake from the RAM wrapper
//   s_rdata                  : response data from the RAM wrapper
module cprv_ram_arb_2to1
    import cprv_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OSTD_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_w_en,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_valid_o,
    input  logic                  m0_ready_i,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_w_en,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_valid_o,
    input  logic                  m1_ready_i,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_valid_o,
    input  logic                  s_ready_i,
    output logic                  s_w_en,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    lock_state_t state;
    lock_state_t state_n;
    id_t         lock_id;
    id_t         lock_id_n;
    id_t         last_grant;
    id_t         gnt_c;
    id_t         head;
    logic        gnt_valid_c;
    logic        req_hs_c;
    logic        rsp_pop_c;
    logic        full;
    logic        empty;

    cprv_tag_fifo #(
        .DEPTH (OSTD_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_hs_c),
        .pop   (rsp_pop_c),
        .din   (gnt_c),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Grant selection: locked grant first, then round-robin on contention
    always_comb begin
        gnt_c = M0;
        if (state == ST_HOLD) begin
            gnt_c = lock_id;
        end else if (m0_valid_i && m1_valid_i) begin
            gnt_c = (last_grant == M0) ? M1 : M0;
        end else if (m1_valid_i) begin
            gnt_c = M1;
        end
    end

    assign gnt_valid_c = ~rst & ~full & ((gnt_c == M1) ? m1_valid_i : m0_valid_i);
    assign req_hs_c    = gnt_valid_c & s_ready_i;

    // Request path to the RAM wrapper
    assign s_valid_o  = gnt_valid_c;
    assign s_w_en     = (gnt_c == M1) ? m1_w_en  : m0_w_en;
    assign s_addr     = (gnt_c == M1) ? m1_addr  : m0_addr;
    assign s_wdata    = (gnt_c == M1) ? m1_wdata : m0_wdata;
    assign m0_ready_o = gnt_valid_c & (gnt_c == M0) & s_ready_i;
    assign m1_ready_o = gnt_valid_c & (gnt_c == M1) & s_ready_i;

    // Lock FSM and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OPEN;
            lock_id    <= M0;
            last_grant <= M1;
        end else begin
            state   <= state_n;
            lock_id <= lock_id_n;
            if (req_hs_c) last_grant <= gnt_c;
        end
    end

    // A stalled request pins the grant until it completes
    always_comb begin
        state_n   = state;
        lock_id_n = lock_id;
        case (state)
            ST_OPEN: begin
                if (s_valid_o && !s_ready_i) begin
                    state_n   = ST_HOLD;
                    lock_id_n = gnt_c;
                end
            end
            ST_HOLD: begin
                if (!s_valid_o || s_ready_i) state_n = ST_OPEN;
            end
            default: state_n = ST_OPEN;
        endcase
    end

    // Response routing by head tag; responses with no tag are sunk
    always_comb begin
        m0_valid_o = 1'b0;
        m1_valid_o = 1'b0;
        s_ready_o  = 1'b0;
        if (!rst) begin
            if (empty) begin
                s_ready_o = 1'b1;
            end else if (head == M1) begin
                m1_valid_o = s_valid_i;
                s_ready_o  = m1_ready_i;
            end else begin
                m0_valid_o = s_valid_i;
                s_ready_o  = m0_ready_i;
            end
        end
    end

    assign rsp_pop_c = s_valid_i & s_ready_o & ~empty;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_cprv_ram_arb_2to1.sv
module tb_cprv_ram_arb_2to1;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 64;

    typedef struct packed {
        logic          id;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } gnt_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] d;
    } rsp_t;

    logic          clk;
    logic          rst;
    logic          m0_valid_i, m0_ready_o, m0_w_en, m0_valid_o, m0_ready_i;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid_i, m1_ready_o, m1_w_en, m1_valid_o, m1_ready_i;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_valid_o, s_ready_i, s_w_en, s_valid_i, s_ready_o;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    int compared   = 0;
    int mismatched = 0;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    // RAM wrapper model state
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rsp_q[$];
    logic          rsp_en;
    logic          stray;
    logic          hs_req, hs_rsp, cap_w;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    logic [DW-1:0] dummy;

    // Monitor scratch
    gnt_t g;
    rsp_t r;
    logic got_id;

    cprv_ram_arb_2to1 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OSTD_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid_i (m0_valid_i),
        .m0_ready_o (m0_ready_o),
        .m0_w_en    (m0_w_en),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_valid_o (m0_valid_o),
        .m0_ready_i (m0_ready_i),
        .m0_rdata   (m0_rdata),
        .m1_valid_i (m1_valid_i),
        .m1_ready_o (m1_ready_o),
        .m1_w_en    (m1_w_en),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_valid_o (m1_valid_o),
        .m1_ready_i (m1_ready_i),
        .m1_rdata   (m1_rdata),
        .s_valid_o  (s_valid_o),
        .s_ready_i  (s_ready_i),
        .s_w_en     (s_w_en),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_rdata    (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_g(input logic id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_gnt.push_back('{id: id, w: w, a: a, d: d});
    endtask

    task automatic exp_r(input logic id, input logic [DW-1:0] d);
        exp_rsp.push_back('{id: id, d: d});
    endtask

    task automatic ram_drive();
        s_valid_i = stray || (rsp_en && rsp_q.size() > 0);
        s_rdata   = (rsp_q.size() > 0 && !stray) ? rsp_q[0] : 64'hBAD0_BAD0;
    endtask

    // RAM wrapper: one response per accepted request, in order, one cycle later
    always begin
        @(negedge clk);
        hs_req = s_valid_o && s_ready_i;
        hs_rsp = s_valid_i && s_ready_o;
        cap_w  = s_w_en;
        cap_a  = s_addr;
        cap_d  = s_wdata;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (hs_rsp && rsp_q.size() > 0) dummy = rsp_q.pop_front();
            if (hs_req) begin
                if (cap_w) begin
                    mem[cap_a] = cap_d;
                    rsp_q.push_back('0);
                end else begin
                    rsp_q.push_back(mem[cap_a]);
                end
            end
        end
        ram_drive();
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid_o && s_ready_i) begin
                got_id = m1_ready_o;
                check("grant_one_hot", 64'(m0_ready_o ^ m1_ready_o), 64'd1);
                if (exp_gnt.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL grant_unexpected: got addr %0h expected none", s_addr);
                end else begin
                    g = exp_gnt.pop_front();
                    check("grant_id", 64'(got_id), 64'(g.id));
                    check("grant_wen", 64'(s_w_en), 64'(g.w));
                    check("grant_addr", 64'(s_addr), 64'(g.a));
                    if (g.w) check("grant_wdata", s_wdata, g.d);
                end
            end
            if ((m0_valid_o && m0_ready_i) || (m1_valid_o && m1_ready_i)) begin
                check("rsp_one_hot", 64'(m0_valid_o & m1_valid_o), 64'd0);
                if (exp_rsp.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rsp_unexpected: got m1=%0d data %0h expected none", m1_valid_o, s_rdata);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_id", 64'(m1_valid_o), 64'(r.id));
                    check("rsp_data", m1_valid_o ? m1_rdata : m0_rdata, r.d);
                end
            end
        end
    end

    // Present a request and hold it until accepted
    task automatic do_req(input logic id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        if (id) begin
            m1_valid_i = 1'b1; m1_w_en = w; m1_addr = a; m1_wdata = d;
        end else begin
            m0_valid_i = 1'b1; m0_w_en = w; m0_addr = a; m0_wdata = d;
        end
        forever begin
            @(negedge clk);
            if ((id ? m1_ready_o : m0_ready_o) === 1'b1) break;
            n++;
            if (n > 200) begin
                compared++;
                mismatched++;
                $display("FAIL req_timeout: got no ready for m%0d addr %0h expected ready", id, a);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id) m1_valid_i = 1'b0;
        else    m0_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_gnt.size() > 0 || exp_rsp.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                compared++;
                mismatched++;
                $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_gnt.size(), exp_rsp.size());
                exp_gnt.delete();
                exp_rsp.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rsp_q.delete();
        ram_drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'h1000 + 64'(i);
        rst = 1'b1;
        m0_valid_i = 1'b1; m0_w_en = 1'b0; m0_addr = '0; m0_wdata = '0; m0_ready_i = 1'b1;
        m1_valid_i = 1'b1; m1_w_en = 1'b0; m1_addr = '0; m1_wdata = '0; m1_ready_i = 1'b1;
        s_ready_i = 1'b1;
        rsp_en = 1'b1;
        stray = 1'b1;
        ram_drive();
        #2;
        check("rst_m0_ready", 64'(m0_ready_o), 64'd0);
        check("rst_m1_ready", 64'(m1_ready_o), 64'd0);
        check("rst_s_valid", 64'(s_valid_o), 64'd0);
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_m0_valid", 64'(m0_valid_o), 64'd0);
        check("rst_m1_valid", 64'(m1_valid_o), 64'd0);
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        stray = 1'b0;
        ram_drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read from m0
        exp_g(1'b0, 1'b0, 7'h05, '0);
        exp_r(1'b0, 64'h1005);
        do_req(1'b0, 1'b0, 7'h05, '0);
        drain();

        // Continuous contention after reset: m0 wins first, then alternate
        do_reset();
        exp_g(1'b0, 1'b0, 7'h01, '0);
        exp_g(1'b1, 1'b0, 7'h02, '0);
        exp_g(1'b0, 1'b0, 7'h03, '0);
        exp_g(1'b1, 1'b0, 7'h04, '0);
        exp_r(1'b0, 64'h1001);
        exp_r(1'b1, 64'h1002);
        exp_r(1'b0, 64'h1003);
        exp_r(1'b1, 64'h1004);
        fork
            begin do_req(1'b0, 1'b0, 7'h01, '0); do_req(1'b0, 1'b0, 7'h03, '0); end
            begin do_req(1'b1, 1'b0, 7'h02, '0); do_req(1'b1, 1'b0, 7'h04, '0); end
        join
        drain();

        // Grant lock: m1 stalled three cycles, m0 arrives one cycle later
        s_ready_i = 1'b0;
        exp_g(1'b1, 1'b0, 7'h06, '0);
        exp_g(1'b0, 1'b0, 7'h07, '0);
        exp_r(1'b1, 64'h1006);
        exp_r(1'b0, 64'h1007);
        fork
            do_req(1'b1, 1'b0, 7'h06, '0);
            begin @(posedge clk); #1; do_req(1'b0, 1'b0, 7'h07, '0); end
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("lock_s_valid", 64'(s_valid_o), 64'd1);
                    check("lock_s_addr", 64'(s_addr), 64'h06);
                    check("lock_m0_ready", 64'(m0_ready_o), 64'd0);
                    @(posedge clk);
                    #1;
                end
                s_ready_i = 1'b1;
            end
        join
        drain();

        // Tag FIFO full: two m0 reads stuck behind m0_ready_i=0 block m1
        m0_ready_i = 1'b0;
        exp_g(1'b0, 1'b0, 7'h08, '0);
        exp_g(1'b0, 1'b0, 7'h09, '0);
        exp_g(1'b1, 1'b0, 7'h0A, '0);
        exp_r(1'b0, 64'h1008);
        exp_r(1'b0, 64'h1009);
        exp_r(1'b1, 64'h100A);
        do_req(1'b0, 1'b0, 7'h08, '0);
        do_req(1'b0, 1'b0, 7'h09, '0);
        fork
            do_req(1'b1, 1'b0, 7'h0A, '0);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("full_m1_ready", 64'(m1_ready_o), 64'd0);
                    check("full_s_valid", 64'(s_valid_o), 64'd0);
                    @(posedge clk);
                    #1;
                end
                m0_ready_i = 1'b1;
            end
        join
        drain();

        // Write from m1, then read-back from m0
        exp_g(1'b1, 1'b1, 7'h10, 64'hDEADBEEF);
        exp_g(1'b0, 1'b0, 7'h10, '0);
        exp_r(1'b1, 64'h0);
        exp_r(1'b0, 64'hDEADBEEF);
        do_req(1'b1, 1'b1, 7'h10, 64'hDEADBEEF);
        do_req(1'b0, 1'b0, 7'h10, '0);
        drain();

        // Reset pulse between clock edges with two tags outstanding
        rsp_en = 1'b0;
        ram_drive();
        exp_g(1'b0, 1'b0, 7'h11, '0);
        exp_g(1'b1, 1'b0, 7'h12, '0);
        do_req(1'b0, 1'b0, 7'h11, '0);
        do_req(1'b1, 1'b0, 7'h12, '0);
        m0_ready_i = 1'b0;
        m1_ready_i = 1'b0;
        m0_valid_i = 1'b1; m0_w_en = 1'b0; m0_addr = 7'h13;
        stray = 1'b1;
        ram_drive();
        #2;
        rst = 1'b1;
        #1;
        check("arst_m0_ready", 64'(m0_ready_o), 64'd0);
        check("arst_s_valid", 64'(s_valid_o), 64'd0);
        check("arst_s_ready", 64'(s_ready_o), 64'd0);
        check("arst_m0_valid", 64'(m0_valid_o), 64'd0);
        check("arst_m1_valid", 64'(m1_valid_o), 64'd0);
        #2;
        rst = 1'b0;
        rsp_q.delete();
        rsp_en = 1'b1;
        ram_drive();
        #1;
        check("post_rst_s_ready", 64'(s_ready_o), 64'd1);
        check("post_rst_m0_valid", 64'(m0_valid_o), 64'd0);
        check("post_rst_m1_valid", 64'(m1_valid_o), 64'd0);
        check("post_rst_m0_ready", 64'(m0_ready_o), 64'd1);
        check("post_rst_s_valid", 64'(s_valid_o), 64'd1);
        m0_valid_i = 1'b0;
        m0_ready_i = 1'b1;
        m1_ready_i = 1'b1;
        @(negedge clk);
        check("stray_s_ready", 64'(s_ready_o), 64'd1);
        check("stray_m0_valid", 64'(m0_valid_o), 64'd0);
        check("stray_m1_valid", 64'(m1_valid_o), 64'd0);
        @(posedge clk);
        #1;
        stray = 1'b0;
        ram_drive();
        repeat (3) @(posedge clk);
        #1;
        drain();
        check("end_gnt_queue", 64'(exp_gnt.size()), 64'd0);
        check("end_rsp_queue", 64'(exp_rsp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cprv_ram_arb_2to1.md
CPRV_RAM_ARB_2TO1 -- requirements
Module: cprv_ram_arb_2to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, RAM data width.
REQ-003 SHALL have parameter OSTD_DEPTH, default 2, the maximum number of accepted requests still awaiting a response (legal range 1..4).
REQ-004 SHALL have one clock, and reset SHALL be asynchronous and active-high.
REQ-005 SHALL provide these ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mK_valid_i  in  1  request valid from requester K (K = 0, 1).
- mK_ready_o  out  1  request accepted from requester K.
- mK_w_en  in  1  write enable for requester K.
- mK_addr  in  ADDR_WIDTH  request address for requester K.
- mK_wdata  in  DATA_WIDTH  write data for requester K.
- mK_valid_o  out  1  response valid to requester K.
- mK_ready_i  in  1  requester K ready for a response.
- mK_rdata  out  DATA_WIDTH  response data to requester K.
- s_valid_o  out  1  request valid to the RAM wrapper.
- s_ready_i  in  1  RAM wrapper ready for a request.
- s_w_en  out  1  write enable to the RAM wrapper.
- s_addr  out  ADDR_WIDTH  address to the RAM wrapper.
- s_wdata  out  DATA_WIDTH  write data to the RAM wrapper.
- s_valid_i  in  1  response valid from the RAM wrapper.
- s_ready_o  out  1  arbiter ready for a RAM response.
- s_rdata  in  DATA_WIDTH  response data from the RAM wrapper.

Function
REQ-006 SHALL count a handshake on any channel only in a cycle where that channel's valid and ready are both high at the clk rising edge.
REQ-007 SHALL treat every accepted request, read or write, as producing exactly one RAM response, returned in acceptance order.
REQ-008 SHALL keep a tag FIFO of OSTD_DEPTH entries; each tag is the ID (0 or 1) of the requester that was granted.
REQ-009 SHALL push the granted ID on each s-request handshake and SHALL pop the oldest tag on each s-response handshake.
REQ-010 SHALL block new grants while the tag FIFO is full: s_valid_o=0 and both mK_ready_o=0; there is no same-cycle pop/push bypass.
REQ-011 SHALL, when exactly one mK_valid_i is high, grant that requester.
REQ-012 SHALL, when both are high, grant the requester other than last_grant (round-robin).
REQ-013 SHALL update last_grant only on an s-request handshake.
REQ-014 SHALL hold the grant once s_valid_o is high with s_ready_i low, until the handshake completes, regardless of the other requester (grant lock).
REQ-015 SHALL drive s_valid_o, s_w_en, s_addr and s_wdata combinationally from the granted requester; s_valid_o=0 when no grant.
REQ-016 SHALL set mK_ready_o = s_ready_i for the granted K only, and SHALL hold the non-granted requester's ready at 0.
REQ-017 SHALL route responses by the head tag H: mH_valid_o = s_valid_i, s_ready_o = mH_ready_i, and the other requester's mK_valid_o = 0.
REQ-018 SHALL drive both mK_rdata from s_rdata at all times.
REQ-019 SHALL, if s_valid_i is high while the tag FIFO is empty, drive s_ready_o=1, assert no mK_valid_o and leave FIFO state unchanged (response dropped).
REQ-020 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged and the count stays within 0..OSTD_DEPTH.

Reset
REQ-021 SHALL on rst, without waiting for clk, empty the tag FIFO and set its count to 0.
REQ-022 SHALL on rst set last_grant=1, so requester 0 wins the first contention.
REQ-023 SHALL have, while rst is high: all mK_ready_o=0, s_valid_o=0, mK_valid_o=0, s_ready_o=0.
REQ-024 SHALL discard responses still in flight when reset is asserted mid-operation; a response arriving after reset deasserts follows REQ-019.

Structure
REQ-025 SHALL define in package cprv_ram_arb_pkg a requester ID typedef (1 bit) and the constants M0=0 and M1=1.
REQ-026 SHALL implement the tag FIFO as sub-module cprv_tag_fifo, parameterised by depth, with ports push, pop, din, dout, full, empty.
REQ-027 SHALL place all other logic (arbiter, grant lock, routing) in the top module, with no further sub-modules.

Verification
REQ-028 SHALL cover: only m0 requests a read of addr 0x05 while the RAM is always ready -> one s handshake with s_addr=0x05, then m0_valid_o with RAM data; m1_valid_o stays 0.
REQ-029 SHALL cover: m0 and m1 held valid continuously after reset -> grants alternate m0, m1, m0, m1, and responses alternate in the same order.
REQ-030 SHALL cover: s_ready_i=0 for 3 cycles while m1 is granted, and m0 raises valid in cycle 2 -> the grant stays on m1 until its handshake, and m0_ready_o stays 0 throughout.
REQ-031 SHALL cover: OSTD_DEPTH=2 with m0_ready_i held 0 and two accepted reads -> the third request sees mK_ready_o=0 until one response is popped.
REQ-032 SHALL cover: m1 writes 0xDEADBEEF to addr 0x10, then m0 reads 0x10 -> m1 receives one write response, and m0 then receives rdata 0xDEADBEEF.
REQ-033 SHALL cover: rst asserted with 2 tags outstanding -> count=0 immediately, and a following stray s_valid_i is dropped with no mK_valid_o.
